// File: rtl/if_id_branch_stage.sv
// IF/ID pipeline register with ID-stage conditional branch resolution.
// Drives the fetch redirect, squashes the wrong-path instruction after a taken
// branch, re-fetches the IF instruction on a stall, and counts taken branches.
module if_id_branch_stage #(
   parameter int unsigned INSTR_W = 16,
   parameter int unsigned PC_W    = 10,
   parameter int unsigned CNT_W   = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [INSTR_W-1:0] iFetchedInst,
   input  logic [PC_W-1:0]    iNew_pc,
   input  logic               iStall,
   input  logic [2:0]         iFlagsA,
   input  logic [2:0]         iFlagsB,
   output logic [INSTR_W-1:0] oInstr,
   output logic [PC_W-1:0]    oPcNext,
   output logic               oBr_taken,
   output logic [PC_W-1:0]    oBr_dir,
   output logic               oSquash,
   output logic [CNT_W-1:0]   oBrCount
);

   localparam int unsigned OP_W    = 6;
   localparam int unsigned OFF_W   = 6;
   localparam int unsigned MAG_W   = 5;
   localparam int unsigned FLAG_N  = 2;
   localparam int unsigned FLAG_Z  = 1;
   localparam int unsigned FLAG_C  = 0;

   // Opcodes shared with the instruction set definitions
   localparam logic [OP_W-1:0] OP_NOP  = 6'h00;
   localparam logic [OP_W-1:0] OP_BAEQ = 6'h10;
   localparam logic [OP_W-1:0] OP_BANE = 6'h11;
   localparam logic [OP_W-1:0] OP_BACS = 6'h12;
   localparam logic [OP_W-1:0] OP_BACC = 6'h13;
   localparam logic [OP_W-1:0] OP_BAMI = 6'h14;
   localparam logic [OP_W-1:0] OP_BAPL = 6'h15;
   localparam logic [OP_W-1:0] OP_BBEQ = 6'h18;
   localparam logic [OP_W-1:0] OP_BBNE = 6'h19;
   localparam logic [OP_W-1:0] OP_BBCS = 6'h1A;
   localparam logic [OP_W-1:0] OP_BBCC = 6'h1B;
   localparam logic [OP_W-1:0] OP_BBMI = 6'h1C;
   localparam logic [OP_W-1:0] OP_BBPL = 6'h1D;

   localparam logic [INSTR_W-1:0] NOP_INSTR = {OP_NOP, (INSTR_W-OP_W)'(0)};
   localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

   logic [OP_W-1:0]  opcode;
   logic [OFF_W-1:0] offset;
   logic [PC_W-1:0]  magnitude;
   logic [PC_W-1:0]  target;
   logic             is_branch;
   logic             cond_true;
   logic             take;

   assign opcode    = oInstr[INSTR_W-1 -: OP_W];
   assign offset    = oInstr[OFF_W-1:0];
   assign magnitude = PC_W'(offset[MAG_W-1:0]);
   assign target    = offset[OFF_W-1] ? (oPcNext - magnitude) : (oPcNext + magnitude);
   assign take      = is_branch & cond_true & ~iStall;

   // Decode the ID instruction into branch / condition-met
   always_comb begin
      is_branch = 1'b0;
      cond_true = 1'b0;
      case (opcode)
         OP_BAEQ: begin is_branch = 1'b1; cond_true =  iFlagsA[FLAG_Z]; end
         OP_BANE: begin is_branch = 1'b1; cond_true = ~iFlagsA[FLAG_Z]; end
         OP_BACS: begin is_branch = 1'b1; cond_true =  iFlagsA[FLAG_C]; end
         OP_BACC: begin is_branch = 1'b1; cond_true = ~iFlagsA[FLAG_C]; end
         OP_BAMI: begin is_branch = 1'b1; cond_true =  iFlagsA[FLAG_N]; end
         OP_BAPL: begin is_branch = 1'b1; cond_true = ~iFlagsA[FLAG_N]; end
         OP_BBEQ: begin is_branch = 1'b1; cond_true =  iFlagsB[FLAG_Z]; end
         OP_BBNE: begin is_branch = 1'b1; cond_true = ~iFlagsB[FLAG_Z]; end
         OP_BBCS: begin is_branch = 1'b1; cond_true =  iFlagsB[FLAG_C]; end
         OP_BBCC: begin is_branch = 1'b1; cond_true = ~iFlagsB[FLAG_C]; end
         OP_BBMI: begin is_branch = 1'b1; cond_true =  iFlagsB[FLAG_N]; end
         OP_BBPL: begin is_branch = 1'b1; cond_true = ~iFlagsB[FLAG_N]; end
         default: begin is_branch = 1'b0; cond_true = 1'b0; end
      endcase
   end

   // Fetch redirect: stall re-fetches the IF instruction (PC has no enable)
   always_comb begin
      oBr_taken = 1'b0;
      oBr_dir   = '0;
      if (!reset) begin
         oBr_taken = 1'b0;
         oBr_dir   = '0;
      end else if (iStall) begin
         oBr_taken = 1'b1;
         oBr_dir   = iNew_pc - PC_W'(1);
      end else if (take) begin
         oBr_taken = 1'b1;
         oBr_dir   = target;
      end
   end

   // IF/ID register: hold on stall, inject one bubble after a taken branch
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         oInstr  <= NOP_INSTR;
         oPcNext <= '0;
         oSquash <= 1'b0;
      end else if (iStall) begin
         oInstr  <= oInstr;
         oPcNext <= oPcNext;
         oSquash <= oSquash;
      end else if (take) begin
         oInstr  <= NOP_INSTR;
         oPcNext <= iNew_pc;
         oSquash <= 1'b1;
      end else begin
         oInstr  <= iFetchedInst;
         oPcNext <= iNew_pc;
         oSquash <= 1'b0;
      end
   end

   // Saturating taken-branch counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         oBrCount <= '0;
      end else if (take && (oBrCount != CNT_MAX)) begin
         oBrCount <= oBrCount + CNT_W'(1);
      end
   end

endmodule
